// File: rtl/swi_debouncer.sv
// Switch-bank reader: 2-FF synchroniser, per-bit debounce, and a valid/ready change-event queue.
// Optional macro SWI_EVT_COUNT_EN adds an 8-bit wrapping count of accepted events (evt_count).
module swi_debouncer #(
  parameter int NBITS_TOP       = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                 clk_2,
  input  logic                 reset_n,
  input  logic [NBITS_TOP-1:0] SWI,
  output logic [NBITS_TOP-1:0] sw_stable,
  output logic                 chg_valid,
  output logic [NBITS_TOP-1:0] chg_data,
  output logic [NBITS_TOP-1:0] chg_mask,
  input  logic                 chg_ready,
`ifdef SWI_EVT_COUNT_EN
  output logic [7:0]           evt_count,
`endif
  output logic                 overrun
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NBITS_TOP-1:0]            sync1_q, sync1_d;
  logic [NBITS_TOP-1:0]            sync2_q, sync2_d;
  logic [NBITS_TOP-1:0]            sw_stable_q, sw_stable_d;
  logic [NBITS_TOP-1:0][CNT_W-1:0] cnt_q, cnt_d;
  state_e                          state_q, state_d;
  logic                            chg_valid_q, chg_valid_d;
  logic [NBITS_TOP-1:0]            chg_data_q, chg_data_d;
  logic [NBITS_TOP-1:0]            chg_mask_q, chg_mask_d;
  logic                            overrun_q, overrun_d;
  logic [NBITS_TOP-1:0]            diff_s;
  logic                            change_s;
  logic                            accept_s;

  // Synchroniser next-state.
  always_comb begin
    sync1_d = SWI;
    sync2_d = sync1_q;
  end

  // Debounce: a bit must disagree with sw_stable for DEBOUNCE_CYCLES consecutive synced cycles.
  always_comb begin
    sw_stable_d = sw_stable_q;
    cnt_d       = cnt_q;
    for (int i = 0; i < NBITS_TOP; i++) begin
      if (sync2_q[i] == sw_stable_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] == CNT_MAX) begin
        sw_stable_d[i] = ~sw_stable_q[i];
        cnt_d[i]       = CNT_ZERO;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  assign diff_s   = sw_stable_d ^ sw_stable_q;
  assign change_s = |diff_s;
  assign accept_s = chg_valid_q & chg_ready;

  // Event FSM: a change while pending merges into the event and flags overrun.
  always_comb begin
    state_d     = state_q;
    chg_valid_d = chg_valid_q;
    chg_data_d  = chg_data_q;
    chg_mask_d  = chg_mask_q;
    overrun_d   = overrun_q;
    case (state_q)
      IDLE: begin
        if (change_s) begin
          chg_data_d  = sw_stable_d;
          chg_mask_d  = diff_s;
          chg_valid_d = 1'b1;
          state_d     = PEND;
        end else begin
          state_d = IDLE;
        end
      end
      PEND: begin
        if (accept_s) begin
          overrun_d = 1'b0;
          if (change_s) begin
            chg_data_d = sw_stable_d;
            chg_mask_d = diff_s;
            state_d    = PEND;
          end else begin
            chg_valid_d = 1'b0;
            chg_mask_d  = {NBITS_TOP{1'b0}};
            state_d     = IDLE;
          end
        end else begin
          if (change_s) begin
            chg_data_d = sw_stable_d;
            chg_mask_d = chg_mask_q | diff_s;
            overrun_d  = 1'b1;
          end else begin
            state_d = PEND;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        chg_valid_d = 1'b0;
        chg_mask_d  = {NBITS_TOP{1'b0}};
        overrun_d   = 1'b0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= {NBITS_TOP{1'b0}};
      sync2_q     <= {NBITS_TOP{1'b0}};
      sw_stable_q <= {NBITS_TOP{1'b0}};
      cnt_q       <= {NBITS_TOP{CNT_ZERO}};
      state_q     <= IDLE;
      chg_valid_q <= 1'b0;
      chg_data_q  <= {NBITS_TOP{1'b0}};
      chg_mask_q  <= {NBITS_TOP{1'b0}};
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sw_stable_q <= sw_stable_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      chg_valid_q <= chg_valid_d;
      chg_data_q  <= chg_data_d;
      chg_mask_q  <= chg_mask_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef SWI_EVT_COUNT_EN
  logic [7:0] evt_count_q, evt_count_d;

  // Accepted-event counter, wraps naturally at 8 bits.
  always_comb begin
    if (accept_s) begin
      evt_count_d = evt_count_q + 8'd1;
    end else begin
      evt_count_d = evt_count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      evt_count_q <= 8'd0;
    end else begin
      evt_count_q <= evt_count_d;
    end
  end

  assign evt_count = evt_count_q;
`endif

  assign sw_stable = sw_stable_q;
  assign chg_valid = chg_valid_q;
  assign chg_data  = chg_data_q;
  assign chg_mask  = chg_mask_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_swi_debouncer.sv
// Directed bench for swi_debouncer (DEBOUNCE_CYCLES=4); observed word is
// {sw_stable, chg_valid, chg_data, chg_mask, overrun}.
module tb_swi_debouncer;

  logic       clk_2 = 1'b0;
  logic       reset_n;
  logic [7:0] SWI;
  logic [7:0] sw_stable;
  logic       chg_valid;
  logic [7:0] chg_data;
  logic [7:0] chg_mask;
  logic       chg_ready;
  logic       overrun;
`ifdef SWI_EVT_COUNT_EN
  logic [7:0] evt_count;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [25:0] exp_v;
  logic [25:0] obs;

  assign obs = {sw_stable, chg_valid, chg_data, chg_mask, overrun};

  always #5 clk_2 = ~clk_2;

  swi_debouncer #(.NBITS_TOP(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk_2     (clk_2),
    .reset_n   (reset_n),
    .SWI       (SWI),
    .sw_stable (sw_stable),
    .chg_valid (chg_valid),
    .chg_data  (chg_data),
    .chg_mask  (chg_mask),
    .chg_ready (chg_ready),
`ifdef SWI_EVT_COUNT_EN
    .evt_count (evt_count),
`endif
    .overrun   (overrun)
  );

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_2);
    #1;
  endtask

  // Reset with SWI held; the first rising edge after release is edge 0.
  task automatic do_reset(input logic [7:0] sw);
    reset_n   = 1'b0;
    SWI       = sw;
    chg_ready = 1'b0;
    repeat (2) @(posedge clk_2);
    @(negedge clk_2);
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    SWI       = 8'hFF;
    chg_ready = 1'b0;
    repeat (2) @(posedge clk_2);
    #1;
    exp_v = {8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL reset_state obs=%h exp=%h", obs, exp_v); end
`ifdef SWI_EVT_COUNT_EN
    checks++; if (evt_count !== 8'd0) begin errors++; $display("FAIL reset_evt_count obs=%h exp=00", evt_count); end
`endif
    @(negedge clk_2);
    reset_n = 1'b1;
    tick(5);
    exp_v = {8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL t1_edge4 obs=%h exp=%h", obs, exp_v); end
    tick(1);
    exp_v = {8'hFF, 1'b1, 8'hFF, 8'hFF, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL t1_edge5 obs=%h exp=%h", obs, exp_v); end
    chg_ready = 1'b1;
    tick(1);
    chg_ready = 1'b0;
    exp_v = {8'hFF, 1'b0, 8'hFF, 8'h00, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL t1_accept obs=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_glitch;
    do_reset(8'h00);
    tick(1);
    exp_v = 26'd0;
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL glitch_start obs=%h exp=%h", obs, exp_v); end
    // Four-cycle pulse is just long enough; its return edge is also accepted.
    SWI = 8'h08;
    tick(4);
    SWI = 8'h00;
    tick(1);
    exp_v = 26'd0;
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL pulse4_early obs=%h exp=%h", obs, exp_v); end
    tick(1);
    exp_v = {8'h08, 1'b1, 8'h08, 8'h08, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL pulse4_rise obs=%h exp=%h", obs, exp_v); end
    tick(4);
    exp_v = {8'h00, 1'b1, 8'h00, 8'h08, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL pulse4_fall obs=%h exp=%h", obs, exp_v); end
    chg_ready = 1'b1;
    tick(1);
    chg_ready = 1'b0;
    exp_v = 26'd0;
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL pulse4_accept obs=%h exp=%h", obs, exp_v); end
    SWI = 8'h08;
    tick(3);
    SWI = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++; if (obs !== 26'd0) begin errors++; $display("FAIL glitch3 cyc=%0d obs=%h exp=0", i, obs); end
    end
  endtask

  task automatic test_hold;
    chg_ready = 1'b1;
    SWI       = 8'h05;
    tick(2);
    checks++; if (obs !== 26'd0) begin errors++; $display("FAIL ready_idle obs=%h exp=0", obs); end
    chg_ready = 1'b0;
    tick(4);
    exp_v = {8'h05, 1'b1, 8'h05, 8'h05, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL hold_rise obs=%h exp=%h", obs, exp_v); end
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL hold cyc=%0d obs=%h exp=%h", i, obs, exp_v); end
    end
    chg_ready = 1'b1;
    tick(1);
    chg_ready = 1'b0;
    exp_v = {8'h05, 1'b0, 8'h05, 8'h00, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL hold_accept obs=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_overrun;
    do_reset(8'h00);
    SWI = 8'h01;
    tick(6);
    exp_v = {8'h01, 1'b1, 8'h01, 8'h01, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL ovr_first obs=%h exp=%h", obs, exp_v); end
    SWI = 8'h03;
    tick(5);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL ovr_before obs=%h exp=%h", obs, exp_v); end
    tick(1);
    exp_v = {8'h03, 1'b1, 8'h03, 8'h03, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL ovr_merge obs=%h exp=%h", obs, exp_v); end
    chg_ready = 1'b1;
    tick(1);
    chg_ready = 1'b0;
    exp_v = {8'h03, 1'b0, 8'h03, 8'h00, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL ovr_accept obs=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_back_to_back;
    SWI = 8'h02;
    tick(6);
    exp_v = {8'h02, 1'b1, 8'h02, 8'h01, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL b2b_first obs=%h exp=%h", obs, exp_v); end
    SWI = 8'h82;
    tick(5);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL b2b_before obs=%h exp=%h", obs, exp_v); end
    chg_ready = 1'b1;
    tick(1);
    chg_ready = 1'b0;
    exp_v = {8'h82, 1'b1, 8'h82, 8'h80, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL b2b_reload obs=%h exp=%h", obs, exp_v); end
    chg_ready = 1'b1;
    tick(1);
    chg_ready = 1'b0;
    exp_v = {8'h82, 1'b0, 8'h82, 8'h00, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL b2b_accept obs=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_reset_mid;
    SWI = 8'h5A;
    tick(6);
    exp_v = {8'h5A, 1'b1, 8'h5A, 8'hD8, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL mid_pending obs=%h exp=%h", obs, exp_v); end
    reset_n = 1'b0;
    #1;
    checks++; if (obs !== 26'd0) begin errors++; $display("FAIL mid_async_clear obs=%h exp=0", obs); end
    repeat (2) @(posedge clk_2);
    @(negedge clk_2);
    reset_n = 1'b1;
    tick(5);
    checks++; if (obs !== 26'd0) begin errors++; $display("FAIL mid_redebounce obs=%h exp=0", obs); end
    tick(1);
    exp_v = {8'h5A, 1'b1, 8'h5A, 8'h5A, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL mid_after obs=%h exp=%h", obs, exp_v); end
    chg_ready = 1'b1;
    tick(1);
    chg_ready = 1'b0;
    exp_v = {8'h5A, 1'b0, 8'h5A, 8'h00, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL mid_accept obs=%h exp=%h", obs, exp_v); end
  endtask

`ifdef SWI_EVT_COUNT_EN
  task automatic test_evt_count;
    do_reset(8'h00);
    tick(1);
    checks++; if (evt_count !== 8'd0) begin errors++; $display("FAIL evt_start obs=%h exp=00", evt_count); end
    for (int n = 1; n <= 256; n++) begin
      SWI = (n % 2 == 1) ? 8'h01 : 8'h00;
      tick(6);
      chg_ready = 1'b1;
      tick(1);
      chg_ready = 1'b0;
      if (n == 3) begin
        checks++; if (evt_count !== 8'd3) begin errors++; $display("FAIL evt_3 obs=%h exp=03", evt_count); end
      end
      if (n == 255) begin
        checks++; if (evt_count !== 8'd255) begin errors++; $display("FAIL evt_255 obs=%h exp=ff", evt_count); end
      end
      if (n == 256) begin
        checks++; if (evt_count !== 8'd0) begin errors++; $display("FAIL evt_wrap obs=%h exp=00", evt_count); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_glitch();
    test_hold();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
`ifdef SWI_EVT_COUNT_EN
    test_evt_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
